// File: rtl/wb_master_seq.sv
// ---------------------------------------------------------------------------
// wb_master_seq
//
// Purpose:
//   Wishbone classic single-cycle initiator. It accepts one read or write
//   command at a time on a valid/ready command port and runs exactly one
//   Wishbone cycle per command. The wait for wb_ack_i is bounded: after
//   TIMEOUT_CYCLES bus cycles without an ack the cycle is aborted. The result
//   (read data, or a timeout flag) is returned on a valid/ready response port.
//
// Parameters:
//   TIMEOUT_CYCLES  bus cycles without ack before abort (1 .. 2^16-1)
//   COUNT_W         width of txn_count_o
//
// Ports:
//   wb_clock_i      in   single clock for all logic
//   wb_reset_n_i    in   asynchronous reset, active-low
//   cmd_valid_i     in   command present
//   cmd_ready_o     out  command accepted on valid & ready (high in IDLE)
//   cmd_we_i        in   1 = write, 0 = read
//   cmd_sel_i       in   byte selects
//   cmd_addr_i      in   byte address
//   cmd_data_i      in   write data
//   rsp_valid_o     out  response present
//   rsp_ready_i     in   response consumed on valid & ready
//   rsp_data_o      out  read data (0 for writes and timeouts)
//   rsp_timeout_o   out  1 = cycle aborted without ack
//   wb_cyc_o        out  Wishbone cycle
//   wb_strobe_o     out  Wishbone strobe (always equal to wb_cyc_o)
//   wb_we_o         out  write enable
//   wb_sel_o        out  byte selects
//   wb_addr_o       out  address
//   wb_data_o       out  write data
//   wb_ack_i        in   slave acknowledge
//   wb_data_i       in   slave read data
//   busy_o          out  any state other than IDLE
//   txn_count_o     out  acked transactions completed, wraps to 0
// ---------------------------------------------------------------------------
module wb_master_seq #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_W        = 16
) (
    input  logic               wb_clock_i,
    input  logic               wb_reset_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [3:0]         cmd_sel_i,
    input  logic [31:0]        cmd_addr_i,
    input  logic [31:0]        cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_data_o,
    output logic               rsp_timeout_o,
    output logic               wb_cyc_o,
    output logic               wb_strobe_o,
    output logic               wb_we_o,
    output logic [3:0]         wb_sel_o,
    output logic [31:0]        wb_addr_o,
    output logic [31:0]        wb_data_o,
    input  logic               wb_ack_i,
    input  logic [31:0]        wb_data_i,
    output logic               busy_o,
    output logic [COUNT_W-1:0] txn_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen on the last permitted bus cycle; the counter is
    // cleared on accept, so it reads 0 during the first bus cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] timeout_count;
    logic        cmd_accept;
    logic        rsp_accept;
    logic        bus_ack;
    logic        bus_expire;

    assign cmd_accept = cmd_valid_i & cmd_ready_o;
    assign rsp_accept = rsp_valid_o & rsp_ready_i;
    assign bus_ack    = (state == BUS) & wb_ack_i;
    // Ack has priority over expiry when both land in the same cycle.
    assign bus_expire = (state == BUS) & ~wb_ack_i & (timeout_count == TIMEOUT_LAST);

    // State register. The async reset returns to IDLE immediately, which
    // drops cyc/stb without waiting for an edge because they decode state.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_accept)             state_next = BUS;
            BUS:     if (bus_ack || bus_expire)  state_next = RESP;
            RESP:    if (rsp_accept)             state_next = IDLE;
            default:                             state_next = IDLE;
        endcase
    end

    // Output decode. All handshake and bus-qualifier outputs are pure
    // functions of state so they stay glitch-consistent with the FSM.
    always_comb begin
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        wb_cyc_o    = 1'b0;
        busy_o      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            BUS:     wb_cyc_o    = 1'b1;
            RESP:    rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign wb_strobe_o = wb_cyc_o;

    // Command capture. These registers only load on accept, so they keep the
    // last command's values outside BUS and are zero only after reset.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            wb_addr_o <= 32'h0;
            wb_data_o <= 32'h0;
        end else if (cmd_accept) begin
            wb_we_o   <= cmd_we_i;
            wb_sel_o  <= cmd_sel_i;
            wb_addr_o <= cmd_addr_i;
            wb_data_o <= cmd_data_i;
        end
    end

    // Bus wait counter: cleared on accept, advances every bus cycle.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            timeout_count <= 16'h0;
        end else if (cmd_accept) begin
            timeout_count <= 16'h0;
        end else if (state == BUS) begin
            timeout_count <= timeout_count + 16'd1;
        end
    end

    // Response capture at the end of the bus phase; held through RESP.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            rsp_data_o    <= 32'h0;
            rsp_timeout_o <= 1'b0;
        end else if (bus_ack) begin
            rsp_data_o    <= wb_we_o ? 32'h0 : wb_data_i;
            rsp_timeout_o <= 1'b0;
        end else if (bus_expire) begin
            rsp_data_o    <= 32'h0;
            rsp_timeout_o <= 1'b1;
        end
    end

    // Completed-transaction counter; aborted cycles are not counted.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            txn_count_o <= '0;
        end else if (rsp_accept && !rsp_timeout_o) begin
            txn_count_o <= txn_count_o + COUNT_W'(1);
        end
    end

endmodule
